// File: rtl/dmac_cfg_pkg.sv
// rtl/dmac_cfg_pkg.sv - register map constants for the DMA channel configuration block
// Purpose: shared VERSION value, global register offsets, channel window base/stride
//          and per-channel register offsets used by dmac_cfg_mc and its bench.
package dmac_cfg_pkg;

  localparam logic [31:0] VERSION = 32'h0001_2025;

  // Global registers
  localparam logic [11:0] OFF_VERSION  = 12'h000;
  localparam logic [11:0] OFF_CH_CNT   = 12'h004;
  localparam logic [11:0] OFF_IRQ_STAT = 12'h008;
  localparam logic [11:0] OFF_IRQ_EN   = 12'h00C;

  // Channel window: channel n lives at CH_BASE + CH_STRIDE*n
  localparam logic [11:0] CH_BASE   = 12'h100;
  localparam logic [11:0] CH_STRIDE = 12'h020;

  // Offsets inside one channel window
  localparam logic [4:0] CH_SRC    = 5'h00;
  localparam logic [4:0] CH_DST    = 5'h04;
  localparam logic [4:0] CH_LEN    = 5'h08;
  localparam logic [4:0] CH_START  = 5'h0C;
  localparam logic [4:0] CH_STATUS = 5'h10;

endpackage

// File: rtl/dmac_cfg_ch.sv
// rtl/dmac_cfg_ch.sv - one DMA channel: address/length registers, start pulse, done tracking
// Ports: clk, rst_n; wr_src/wr_dst/wr_len/wr_start qualified write strobes with wdata;
//        done engine idle level; src_addr/dst_addr/byte_len register outputs;
//        start one-cycle pulse; busy (pend | !done); done_rise (0->1 edge of done).
module dmac_cfg_ch
  import dmac_cfg_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_src,
  input  logic             wr_dst,
  input  logic             wr_len,
  input  logic             wr_start,
  input  logic [31:0]      wdata,
  input  logic             done,
  output logic [31:0]      src_addr,
  output logic [31:0]      dst_addr,
  output logic [LEN_W-1:0] byte_len,
  output logic             start,
  output logic             busy,
  output logic             done_rise
);

  logic pend;
  logic done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_addr <= '0;
      dst_addr <= '0;
      byte_len <= '0;
      start    <= 1'b0;
      pend     <= 1'b0;
      done_q   <= 1'b1;  // treat the engine as idle so reset release is not a rising edge
    end else begin
      if (wr_src) src_addr <= wdata;
      if (wr_dst) dst_addr <= wdata;
      if (wr_len) byte_len <= wdata[LEN_W-1:0];
      start  <= wr_start;
      done_q <= done;
      // pend covers the gap between the start pulse and the engine dropping done
      if (wr_start)   pend <= 1'b1;
      else if (!done) pend <= 1'b0;
    end
  end

  assign busy      = pend | ~done;
  assign done_rise = done & ~done_q;

endmodule

// File: rtl/dmac_cfg_mc.sv
// rtl/dmac_cfg_mc.sv - APB configuration block for a multi-channel DMA controller
// Ports: clk, rst_n; APB slave psel_i/penable_i/pwrite_i/paddr_i/pwdata_i with
//        pready_o/prdata_o/pslverr_o; per-channel src_addr_o/dst_addr_o/byte_len_o
//        (channel n in slice n), start_o pulses, done_i idle levels; irq_o level interrupt.
module dmac_cfg_mc
  import dmac_cfg_pkg::*;
#(
  parameter int CH_CNT = 4,
  parameter int LEN_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    psel_i,
  input  logic                    penable_i,
  input  logic                    pwrite_i,
  input  logic [11:0]             paddr_i,
  input  logic [31:0]             pwdata_i,
  output logic                    pready_o,
  output logic [31:0]             prdata_o,
  output logic                    pslverr_o,
  output logic [CH_CNT*32-1:0]    src_addr_o,
  output logic [CH_CNT*32-1:0]    dst_addr_o,
  output logic [CH_CNT*LEN_W-1:0] byte_len_o,
  output logic [CH_CNT-1:0]       start_o,
  input  logic [CH_CNT-1:0]       done_i,
  output logic                    irq_o
);

  localparam logic [11:0] CH_END   = 12'(CH_BASE + CH_STRIDE * CH_CNT);
  localparam logic [6:0]  CH_CNT_L = 7'(CH_CNT);

  logic [11:0]       addr_w;
  logic [11:0]       ch_rel;
  logic [6:0]        ch_idx;
  logic [4:0]        ch_off;
  logic              is_glob, glob_ro, ch_ok, ch_map, mapped;
  logic              is_src, is_dst, is_len, is_start, is_status;
  logic [CH_CNT-1:0] ch_hit, busy, rise;
  logic              sel_busy, err, wr_ok, rd_setup;
  logic [31:0]       rd_data;
  logic [CH_CNT-1:0] irq_stat, irq_en, stat_clr;

  // Byte address with the sub-word bits masked off
  assign addr_w  = paddr_i & 12'hFFC;
  assign ch_rel  = addr_w - CH_BASE;
  assign ch_idx  = ch_rel[11:5];  // CH_STRIDE is 0x20
  assign ch_off  = ch_rel[4:0];

  assign is_glob = (addr_w[11:4] == 8'h00);
  assign glob_ro = (addr_w == OFF_VERSION) | (addr_w == OFF_CH_CNT);
  assign ch_ok   = (addr_w >= CH_BASE) & (addr_w < CH_END) & (ch_idx < CH_CNT_L);

  assign is_src    = (ch_off == CH_SRC);
  assign is_dst    = (ch_off == CH_DST);
  assign is_len    = (ch_off == CH_LEN);
  assign is_start  = (ch_off == CH_START);
  assign is_status = (ch_off == CH_STATUS);

  assign ch_map = ch_ok & (is_src | is_dst | is_len | is_start | is_status);
  assign mapped = is_glob | ch_map;

  always_comb begin
    ch_hit = '0;
    for (int n = 0; n < CH_CNT; n++) ch_hit[n] = ch_ok & (ch_idx == 7'(n));
  end

  assign sel_busy = |(ch_hit & busy);

  // Every field write of a busy channel is refused, STATUS is never writable
  assign err = ~mapped
             | (pwrite_i & glob_ro)
             | (pwrite_i & ch_map & is_status)
             | (pwrite_i & ch_map & ~is_status & sel_busy);

  assign wr_ok     = psel_i & penable_i & pwrite_i & ~err;
  assign rd_setup  = psel_i & ~penable_i & ~pwrite_i;
  assign pslverr_o = psel_i & penable_i & err;
  assign pready_o  = 1'b1;

  genvar g;
  generate
    for (g = 0; g < CH_CNT; g++) begin : g_ch
      dmac_cfg_ch #(.LEN_W(LEN_W)) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_src    (wr_ok & ch_hit[g] & is_src),
        .wr_dst    (wr_ok & ch_hit[g] & is_dst),
        .wr_len    (wr_ok & ch_hit[g] & is_len),
        .wr_start  (wr_ok & ch_hit[g] & is_start & pwdata_i[0]),
        .wdata     (pwdata_i),
        .done      (done_i[g]),
        .src_addr  (src_addr_o[32*g +: 32]),
        .dst_addr  (dst_addr_o[32*g +: 32]),
        .byte_len  (byte_len_o[LEN_W*g +: LEN_W]),
        .start     (start_o[g]),
        .busy      (busy[g]),
        .done_rise (rise[g])
      );
    end
  endgenerate

  always_comb begin
    rd_data = '0;
    if (is_glob) begin
      if (addr_w == OFF_VERSION)  rd_data = VERSION;
      if (addr_w == OFF_CH_CNT)   rd_data = 32'(CH_CNT);
      if (addr_w == OFF_IRQ_STAT) rd_data = 32'(irq_stat);
      if (addr_w == OFF_IRQ_EN)   rd_data = 32'(irq_en);
    end
    for (int n = 0; n < CH_CNT; n++) begin
      if (ch_hit[n]) begin
        if (is_src)    rd_data = src_addr_o[32*n +: 32];
        if (is_dst)    rd_data = dst_addr_o[32*n +: 32];
        if (is_len)    rd_data = 32'(byte_len_o[LEN_W*n +: LEN_W]);
        if (is_status) rd_data = {31'b0, ~busy[n]};
      end
    end
  end

  assign stat_clr = (wr_ok & (addr_w == OFF_IRQ_STAT)) ? pwdata_i[CH_CNT-1:0] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_stat <= '0;
      irq_en   <= '0;
      irq_o    <= 1'b0;
      prdata_o <= '0;
    end else begin
      // a completion in the same cycle as its W1C clear is kept
      irq_stat <= (irq_stat & ~stat_clr) | rise;
      if (wr_ok & (addr_w == OFF_IRQ_EN)) irq_en <= pwdata_i[CH_CNT-1:0];
      irq_o <= |(irq_stat & irq_en);
      if (rd_setup) prdata_o <= err ? 32'h0 : rd_data;
    end
  end

endmodule

// File: tb/tb_dmac_cfg_mc.sv
// tb/tb_dmac_cfg_mc.sv - directed self-checking bench for dmac_cfg_mc
module tb_dmac_cfg_mc;

  localparam int CH = 4;
  localparam int LW = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0]       paddr = '0;
  logic [31:0]       pwdata = '0;
  logic              pready, pslverr, irq;
  logic [31:0]       prdata;
  logic [CH*32-1:0]  src_addr, dst_addr;
  logic [CH*LW-1:0]  byte_len;
  logic [CH-1:0]     start, done_i;
  logic [CH-1:0]     rise_at_access = '0;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  dmac_cfg_mc #(.CH_CNT(CH), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata),
    .pready_o(pready), .prdata_o(prdata), .pslverr_o(pslverr),
    .src_addr_o(src_addr), .dst_addr_o(dst_addr), .byte_len_o(byte_len),
    .start_o(start), .done_i(done_i), .irq_o(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_val(tag, e);
    check(obs);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic exp_err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    expect_val($sformatf("wr_err_%h", a), 32'(exp_err));
    @(posedge clk); #1;
    penable = 1'b1;
    done_i  = done_i | rise_at_access;
    @(negedge clk);
    check(32'(pslverr));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd(input logic [11:0] a, input logic [31:0] e, input logic exp_err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    expect_val($sformatf("rd_data_%h", a), e);
    expect_val($sformatf("rd_err_%h", a), 32'(exp_err));
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    check(prdata);
    check(32'(pslverr));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    done_i = 4'hF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start", 32'(start), 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_prdata", prdata, 32'h0);
    chk("rst_pslverr", 32'(pslverr), 32'h0);
    chk("rst_src", src_addr[31:0], 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Reset values and map
    rd(12'h000, 32'h0001_2025, 1'b0);
    rd(12'h002, 32'h0001_2025, 1'b0);
    rd(12'h004, 32'd4, 1'b0);
    rd(12'h008, 32'h0, 1'b0);
    rd(12'h00C, 32'h0, 1'b0);
    for (int c = 0; c < CH; c++) begin
      rd(12'(12'h100 + 32 * c + 0),  32'h0, 1'b0);
      rd(12'(12'h100 + 32 * c + 4),  32'h0, 1'b0);
      rd(12'(12'h100 + 32 * c + 8),  32'h0, 1'b0);
      rd(12'(12'h100 + 32 * c + 16), 32'h1, 1'b0);
    end

    // Channel 2 programming
    wr(12'h140, 32'h0000_1000, 1'b0);
    wr(12'h144, 32'h0000_2000, 1'b0);
    wr(12'h148, 32'h0000_0100, 1'b0);
    rd(12'h140, 32'h0000_1000, 1'b0);
    rd(12'h144, 32'h0000_2000, 1'b0);
    rd(12'h148, 32'h0000_0100, 1'b0);
    chk("src_ch2", src_addr[95:64], 32'h1000);
    chk("src_ch01", src_addr[63:32] | src_addr[31:0], 32'h0);
    chk("src_ch3", src_addr[127:96], 32'h0);
    chk("dst_ch2", dst_addr[95:64], 32'h2000);
    chk("len_ch2", 32'(byte_len[47:32]), 32'h100);
    wr(12'h108, 32'hABCD_1234, 1'b0);
    rd(12'h108, 32'h0000_1234, 1'b0);
    rd(12'h10C, 32'h0, 1'b0);

    // START with bit0 clear does nothing
    wr(12'h10C, 32'hFFFF_FFFE, 1'b0);
    @(negedge clk);
    chk("start_bit0_clear", 32'(start), 32'h0);

    // Channel 1 start
    wr(12'h00C, 32'h2, 1'b0);
    wr(12'h12C, 32'h1, 1'b0);
    @(negedge clk);
    chk("start_pulse", 32'(start), 32'h2);
    @(negedge clk);
    chk("start_pulse_end", 32'(start), 32'h0);
    rd(12'h130, 32'h0, 1'b0);

    // Busy channel and bad address errors
    wr(12'h120, 32'hDEAD_BEEF, 1'b1);
    rd(12'h120, 32'h0, 1'b0);
    wr(12'h12C, 32'h1, 1'b1);
    @(negedge clk);
    chk("start_refused", 32'(start), 32'h0);
    wr(12'h140, 32'h0000_5555, 1'b0);
    rd(12'h140, 32'h0000_5555, 1'b0);
    rd(12'h200, 32'h0, 1'b1);
    rd(12'h180, 32'h0, 1'b1);
    rd(12'h010, 32'h0, 1'b1);
    wr(12'h000, 32'h1234_5678, 1'b1);
    wr(12'h004, 32'h9, 1'b1);
    rd(12'h004, 32'd4, 1'b0);
    wr(12'h110, 32'h0, 1'b1);

    // Engine runs and completes
    cyc(1);
    done_i[1] = 1'b0;
    cyc(2);
    rd(12'h130, 32'h0, 1'b0);
    chk("irq_before_done", 32'(irq), 32'h0);
    done_i[1] = 1'b1;
    cyc(3);
    chk("irq_after_done", 32'(irq), 32'h1);
    rd(12'h130, 32'h1, 1'b0);
    rd(12'h008, 32'h2, 1'b0);
    wr(12'h00C, 32'h0, 1'b0);
    cyc(1);
    chk("irq_masked", 32'(irq), 32'h0);
    wr(12'h00C, 32'h2, 1'b0);
    cyc(1);
    chk("irq_unmasked", 32'(irq), 32'h1);

    // Set beats W1C clear in the same cycle
    done_i[1] = 1'b0;
    cyc(2);
    rise_at_access = 4'b0010;
    wr(12'h008, 32'h2, 1'b0);
    rise_at_access = 4'b0000;
    rd(12'h008, 32'h2, 1'b0);
    wr(12'h008, 32'h2, 1'b0);
    @(negedge clk);
    chk("irq_reg_delay", 32'(irq), 32'h1);
    @(negedge clk);
    chk("irq_cleared", 32'(irq), 32'h0);
    rd(12'h008, 32'h0, 1'b0);

    // Reset during START access phase
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 12'h10C; pwdata = 32'h1;
    @(posedge clk); #1;
    penable = 1'b1; rst_n = 1'b0;
    @(negedge clk);
    chk("rst_access_start", 32'(start), 32'h0);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_start0", 32'(start), 32'h0);
    @(negedge clk);
    chk("rel_start1", 32'(start), 32'h0);
    chk("rel_irq", 32'(irq), 32'h0);
    chk("rel_src_all", src_addr[127:96] | src_addr[95:64] | src_addr[63:32] | src_addr[31:0], 32'h0);
    chk("rel_len_all", 32'(byte_len[63:32] | byte_len[31:0]), 32'h0);
    rd(12'h140, 32'h0, 1'b0);
    rd(12'h00C, 32'h0, 1'b0);
    rd(12'h110, 32'h1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
